inst_encoder: RTL

//  Packs RV32I instruction fields plus a 32-bit signed immediate into a 32-bit

---
 rtl/inst_encoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields and a signed immediate into a 32-bit
// instruction word using the I/S/B/U/J immediate layouts.
// Two-stage valid/ready pipeline:
//   stage 1 decodes the format and range-checks the immediate;
//   stage 2 packs the bits.
// Words that cannot be encoded come out as a NOP (addi x0,x0,0) with out_err set.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake
//   in_opcode            opcode, selects the format
//   in_rd/rs1/rs2/funct3 register and funct3 fields
//   in_imm               signed immediate (byte offset for B/J, full value for U)
//   out_valid/out_ready  output handshake
//   out_inst             encoded word, or 32'h00000013 on error
//   out_err              word is an error substitute
//   err_count            saturating count of errored words delivered
module inst_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    fmt_t        fmt_d;
    logic        range_ok;

    logic        s1_valid;
    fmt_t        s1_fmt;
    logic        s1_err;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [31:0] s1_imm;

    logic [31:0] pack;
    logic        s2_load;

    // An immediate fits N+1 signed bits when everything from bit N upward
    // is a copy of the sign.
    logic        fits12, fits13, fits21;
    assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        fmt_d    = FMT_BAD;
        range_ok = 1'b0;
        case (in_opcode)
            7'b0000011, 7'b0010011, 7'b1100111: begin
                fmt_d    = FMT_I;
                range_ok = fits12;
            end
            7'b0100011: begin
                fmt_d    = FMT_S;
                range_ok = fits12;
            end
            7'b1100011: begin
                fmt_d    = FMT_B;
                range_ok = fits13 & ~in_imm[0];
            end
            7'b0110111, 7'b0010111: begin
                fmt_d    = FMT_U;
                range_ok = ~(|in_imm[11:0]);
            end
            7'b1101111: begin
                fmt_d    = FMT_J;
                range_ok = fits21 & ~in_imm[0];
            end
            default: begin
                fmt_d    = FMT_BAD;
                range_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        pack = NOP;
        if (!s1_err) begin
            case (s1_fmt)
                FMT_I: pack = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                FMT_S: pack = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                               s1_imm[4:0], s1_opcode};
                FMT_B: pack = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                               s1_imm[4:1], s1_imm[11], s1_opcode};
                FMT_U: pack = {s1_imm[31:12], s1_rd, s1_opcode};
                FMT_J: pack = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                               s1_rd, s1_opcode};
                default: pack = NOP;
            endcase
        end
    end

    // Stage 2 takes a word whenever it is empty or its word leaves this cycle;
    // stage 1 may refill whenever its own word is guaranteed to move on.
    assign s2_load  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_BAD;
            s1_err    <= 1'b0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_imm    <= '0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_fmt    <= fmt_d;
                    s1_err    <= ~range_ok;
                    s1_opcode <= in_opcode;
                    s1_rd     <= in_rd;
                    s1_rs1    <= in_rs1;
                    s1_rs2    <= in_rs2;
                    s1_funct3 <= in_funct3;
                    s1_imm    <= in_imm;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_inst <= pack;
                    out_err  <= s1_err;
                end
            end
            if (out_valid && out_ready && out_err && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
